// File: rtl/btn_cmd_pkg.sv
// Shared types for the button command scheduler: FSM states, command selector
// and button lane indices.
package btn_cmd_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_RUN, CMD_CLR} cmd_t;

  localparam int NUM_BTN = 2;
  localparam int BTN_RUN = 0;
  localparam int BTN_CLR = 1;

endpackage

// File: rtl/btn_debounce.sv
// Counter debouncer for one active-low button: the stable level flips only after
// DEB_CYCLES consecutive cycles of disagreement, and a 1->0 flip emits a press pulse.
module btn_debounce #(
  parameter int DEB_W      = 16,
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic Reset,
  input  logic raw_n,
  output logic stable_n,
  output logic press
);

  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (raw_n != stable_q) begin
      if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        stable_d = raw_n;
        press_d  = ~raw_n;  // only the falling (pressed) transition is an event
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign stable_n = stable_q;
  assign press    = press_q;

endmodule

// File: rtl/btn_cmd_scheduler.sv
// Turns debounced Run / ClearA_LoadB presses into single-cycle datapath commands,
// one in flight at a time, Clear first, completion tracked via dp_busy.
module btn_cmd_scheduler
  import btn_cmd_pkg::*;
#(
  parameter int DEB_W      = 16,
  parameter int DEB_CYCLES = 50000,
  parameter int ACK_CYCLES = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic run_btn_n,
  input  logic clr_btn_n,
  input  logic dp_busy,
  output logic cmd_run,
  output logic cmd_clr,
  output logic ctrl_busy,
  output logic run_pend,
  output logic clr_pend
);

  localparam int ACK_TW = $clog2(ACK_CYCLES + 1);

  logic [NUM_BTN-1:0] raw_n, stable_n, press;
  logic [NUM_BTN-1:0] pend_q, pend_d, pend_clr;
  state_t             state_q, state_d;
  cmd_t               sel_q, sel_d;
  logic [ACK_TW-1:0]  timer_q, timer_d;
  logic               cmd_run_q, cmd_run_d;
  logic               cmd_clr_q, cmd_clr_d;

  assign raw_n = {clr_btn_n, run_btn_n};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_deb
    btn_debounce #(
      .DEB_W      (DEB_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk      (clk),
      .Reset    (Reset),
      .raw_n    (raw_n[b]),
      .stable_n (stable_n[b]),
      .press    (press[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      sel_q   <= CMD_NONE;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (pend_q[BTN_CLR]) begin
          sel_d   = CMD_CLR;
          state_d = ISSUE;
        end else if (pend_q[BTN_RUN]) begin
          sel_d   = CMD_RUN;
          state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK: begin
        // no busy within the window means the datapath finished in one cycle
        if (dp_busy)                         state_d = WAIT_DONE;
        else if (timer_q == ACK_TW'(1))      state_d = IDLE;
      end
      WAIT_DONE: if (!dp_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_run_d = (state_d == ISSUE) && (sel_d == CMD_RUN);
    cmd_clr_d = (state_d == ISSUE) && (sel_d == CMD_CLR);
  end

  always_comb begin
    timer_d  = timer_q;
    pend_clr = '0;
    if (state_q == ISSUE) begin
      timer_d = ACK_TW'(ACK_CYCLES);
      if (sel_q == CMD_RUN) pend_clr[BTN_RUN] = 1'b1;
      if (sel_q == CMD_CLR) pend_clr[BTN_CLR] = 1'b1;
    end else if (state_q == WAIT_ACK && !dp_busy) begin
      timer_d = timer_q - 1'b1;
    end
    // a new press beats a same-cycle issue clear; a press onto a set flag is absorbed
    pend_d = (press & ~stable_n) | (pend_q & ~pend_clr);
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      timer_q   <= '0;
      pend_q    <= '0;
      cmd_run_q <= 1'b0;
      cmd_clr_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      cmd_run_q <= cmd_run_d;
      cmd_clr_q <= cmd_clr_d;
    end
  end

  assign cmd_run   = cmd_run_q;
  assign cmd_clr   = cmd_clr_q;
  assign ctrl_busy = (state_q != IDLE);
  assign run_pend  = pend_q[BTN_RUN];
  assign clr_pend  = pend_q[BTN_CLR];

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Bench for btn_cmd_scheduler with DEB_CYCLES=4, ACK_CYCLES=3: a per-cycle vector
// table for debounce/issue timing, then scoreboarded multi-cycle sequences.
module tb_btn_cmd_scheduler;
  import btn_cmd_pkg::*;

  localparam int DEB = 4;
  localparam int ACK = 3;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic run_btn_n = 1'b1;
  logic clr_btn_n = 1'b1;
  logic dp_busy = 1'b0;
  logic cmd_run, cmd_clr, ctrl_busy, run_pend, clr_pend;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic       run_n;
    logic       clr_n;
    logic       busy;
    logic       rst_n;
    logic [4:0] exp;  // {run_pend, clr_pend, ctrl_busy, cmd_run, cmd_clr}
  } vec_t;

  typedef struct {
    cmd_t kind;
    int   at;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];

  btn_cmd_scheduler #(
    .DEB_W      (16),
    .DEB_CYCLES (DEB),
    .ACK_CYCLES (ACK)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .run_btn_n (run_btn_n),
    .clr_btn_n (clr_btn_n),
    .dp_busy   (dp_busy),
    .cmd_run   (cmd_run),
    .cmd_clr   (cmd_clr),
    .ctrl_busy (ctrl_busy),
    .run_pend  (run_pend),
    .clr_pend  (clr_pend)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic b, input logic rs,
                     input logic [4:0] e, input int n);
    vec_t v;
    v.run_n = r; v.clr_n = c; v.busy = b; v.rst_n = rs; v.exp = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic push(input cmd_t k, input int at);
    sb_t s;
    s.kind = k; s.at = at;
    sb_q.push_back(s);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor: every pulse must match the next expected command and cycle.
  always @(negedge clk) begin
    if (mon_en && (cmd_run || cmd_clr)) begin
      if (cmd_run && cmd_clr) begin
        checks++; failures++;
        $display("FAIL cmd_exclusive @cyc %0d: got both pulses expected one", cyc);
      end else if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_cmd @cyc %0d: got run=%0b clr=%0b expected none",
                 cyc, cmd_run, cmd_clr);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("cmd_kind", cmd_run ? CMD_RUN : CMD_CLR, e.kind);
        chk("cmd_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, m;
    // reset; short Run glitch; Run held with a 5-cycle busy; release
    add(1, 1, 0, 0, 5'b00000, 1);
    add(0, 1, 0, 1, 5'b00000, 3);
    add(1, 1, 0, 1, 5'b00000, 2);
    add(0, 1, 0, 1, 5'b00000, 4);
    add(0, 1, 0, 1, 5'b10000, 1);
    add(0, 1, 0, 1, 5'b10110, 1);
    add(0, 1, 0, 1, 5'b00100, 2);
    add(0, 1, 1, 1, 5'b00100, 5);
    add(0, 1, 0, 1, 5'b00000, 2);
    add(1, 1, 0, 1, 5'b00000, 5);

    @(negedge clk);
    foreach (tbl[i]) begin
      run_btn_n = tbl[i].run_n;
      clr_btn_n = tbl[i].clr_n;
      dp_busy   = tbl[i].busy;
      Reset     = tbl[i].rst_n;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {run_pend, clr_pend, ctrl_busy, cmd_run, cmd_clr},
          tbl[i].exp);
    end
    mon_en = 1'b1;

    // simultaneous presses: Clear first, Run after the ack window expires
    n = cyc;
    run_btn_n = 1'b0; clr_btn_n = 1'b0;
    push(CMD_CLR, n + DEB + 2);
    push(CMD_RUN, n + DEB + 2 + ACK + 2);
    wait_to(n + DEB + 1);
    chk("both_pend", {run_pend, clr_pend, ctrl_busy}, 3'b110);
    wait_to(n + DEB + 2 + ACK);
    chk("ack_wait_busy", ctrl_busy, 1);
    wait_to(n + DEB + 2 + ACK + 1);
    chk("ack_timeout_idle", {ctrl_busy, run_pend}, 2'b01);
    wait_to(n + DEB + 2 + ACK + 3);
    chk("run_pend_cleared", run_pend, 0);
    run_btn_n = 1'b1; clr_btn_n = 1'b1;
    wait_to(n + 30);
    chk("idle_after_pair", ctrl_busy, 0);

    // re-presses during WAIT_DONE collapse into one pending Run
    n = cyc;
    run_btn_n = 1'b0;
    push(CMD_RUN, n + 6);
    wait_to(n + 7);  dp_busy = 1'b1;
    wait_to(n + 8);  run_btn_n = 1'b1;
    wait_to(n + 13); run_btn_n = 1'b0;
    wait_to(n + 19);
    chk("repress1_pend", run_pend, 1);
    run_btn_n = 1'b1;
    wait_to(n + 24); run_btn_n = 1'b0;
    wait_to(n + 30);
    chk("repress2_pend", {run_pend, ctrl_busy}, 2'b11);
    wait_to(n + 32);
    dp_busy = 1'b0;
    push(CMD_RUN, n + 34);
    wait_to(n + 33);
    chk("done_idle", {ctrl_busy, run_pend}, 2'b01);
    wait_to(n + 35);
    chk("second_run_taken", run_pend, 0);
    run_btn_n = 1'b1;
    wait_to(n + 50);

    // reset in WAIT_DONE with Clear pending abandons everything
    n = cyc;
    run_btn_n = 1'b0;
    push(CMD_RUN, n + 6);
    wait_to(n + 7);  dp_busy = 1'b1;
    wait_to(n + 8);  clr_btn_n = 1'b0;
    wait_to(n + 14);
    chk("pre_reset", {clr_pend, ctrl_busy}, 2'b11);
    Reset = 1'b0; run_btn_n = 1'b1; clr_btn_n = 1'b1;
    wait_to(n + 15);
    Reset = 1'b1;
    chk("post_reset", {run_pend, clr_pend, ctrl_busy, cmd_run, cmd_clr}, 5'b00000);
    wait_to(n + 22);
    chk("busy_ignored_idle", {ctrl_busy, clr_pend}, 2'b00);
    wait_to(n + 25); dp_busy = 1'b0;
    wait_to(n + 30);
    m = cyc;
    clr_btn_n = 1'b0;
    push(CMD_CLR, m + 6);
    wait_to(m + 8); clr_btn_n = 1'b1;
    wait_to(m + 20);
    chk("idle_after_reset_cmd", ctrl_busy, 0);

    // glitch train on Clear never reaches the debounce threshold
    for (int i = 0; i < 40; i++) begin
      clr_btn_n = ((i / 2) % 2) != 0;
      @(negedge clk);
      chk("glitch_no_pend", clr_pend, 0);
    end
    clr_btn_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("glitch_quiet", {clr_pend, ctrl_busy}, 2'b00);

    // DEB-1 low cycles: no event; exactly DEB low cycles: one Clear
    clr_btn_n = 1'b0;
    repeat (DEB - 1) @(negedge clk);
    clr_btn_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("short_no_pend", {clr_pend, ctrl_busy}, 2'b00);
    n = cyc;
    clr_btn_n = 1'b0;
    push(CMD_CLR, n + DEB + 2);
    wait_to(n + DEB); clr_btn_n = 1'b1;
    wait_to(n + DEB + 1);
    chk("exact_deb_pend", clr_pend, 1);
    wait_to(n + 25);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
